ppu_reg_responder: RTL and testbench

//  Responder end of the CPU->PPU register interface. Decodes reg_sel/reg_en/reg_rw accesses

---
 rtl/ppu_types_pkg.sv | 35 +++
 rtl/ppu_loopy_addr.sv | 74 +++++++
 rtl/ppu_reg_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_ppu_reg_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_types_pkg.sv
// ppu_types_pkg
//   Shared types and constants for the CPU->PPU register interface.
//   reg_t is also used by the CPU memory map that generates the accesses.
package ppu_types_pkg;

  typedef enum logic [3:0] {
    REG_PPUCTRL   = 4'd0,
    REG_PPUMASK   = 4'd1,
    REG_PPUSTATUS = 4'd2,
    REG_OAMADDR   = 4'd3,
    REG_OAMDATA   = 4'd4,
    REG_PPUSCROLL = 4'd5,
    REG_PPUADDR   = 4'd6,
    REG_PPUDATA   = 4'd7,
    REG_OAMDMA    = 4'd8
  } reg_t;

  // PPUSTATUS bit positions
  localparam int unsigned STATUS_VBLANK = 7;
  localparam int unsigned STATUS_S0     = 6;
  localparam int unsigned STATUS_OVF    = 5;

  // v[13:8] value selecting palette RAM on PPUDATA reads
  localparam logic [5:0] PAL_PAGE = 6'h3F;

  localparam logic [14:0] ADDR_INC_1  = 15'd1;
  localparam logic [14:0] ADDR_INC_32 = 15'd32;

  // PPUDATA read-buffer refill sequencer
  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } fill_state_t;

endpackage

// File: rtl/ppu_loopy_addr.sv
// ppu_loopy_addr
//   Scroll/address latches: t (temporary address), v (current VRAM address),
//   fine_x and the shared first/second write toggle w.
// Ports
//   clock, reset_n   clock, asynchronous active-low reset
//   data             CPU write data
//   ctrl_we          PPUCTRL write (nametable select into t[11:10])
//   scroll_we        PPUSCROLL write
//   addr_we          PPUADDR write
//   w_reset          PPUSTATUS read, clears w
//   v_inc            increment v (by 32 when inc32, else by 1), 15-bit wrap
//   inc32            increment-size select (PPUCTRL bit 2)
//   t, v, fine_x     latch outputs
module ppu_loopy_addr
  import ppu_types_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  data,
  input  logic        ctrl_we,
  input  logic        scroll_we,
  input  logic        addr_we,
  input  logic        w_reset,
  input  logic        v_inc,
  input  logic        inc32,
  output logic [14:0] t,
  output logic [14:0] v,
  output logic [2:0]  fine_x
);

  logic w;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t      <= '0;
      v      <= '0;
      fine_x <= '0;
      w      <= 1'b0;
    end else begin
      if (ctrl_we) begin
        t[11:10] <= data[1:0];
      end else if (scroll_we) begin
        if (!w) begin
          t[4:0] <= data[7:3];
          fine_x <= data[2:0];
          w      <= 1'b1;
        end else begin
          t[14:12] <= data[2:0];
          t[9:5]   <= data[7:3];
          w        <= 1'b0;
        end
      end else if (addr_we) begin
        if (!w) begin
          t[13:8] <= data[5:0];
          t[14]   <= 1'b0;
          w       <= 1'b1;
        end else begin
          t[7:0] <= data;
          v      <= {t[14:8], data};
          w      <= 1'b0;
        end
      end

      if (w_reset) begin
        w <= 1'b0;
      end

      if (v_inc) begin
        v <= v + (inc32 ? ADDR_INC_32 : ADDR_INC_1);
      end
    end
  end

endmodule

// File: rtl/ppu_reg_responder.sv
// ppu_reg_responder
//   Responder end of the CPU->PPU register interface. Decodes accesses,
//   owns PPUCTRL/PPUMASK/PPUSTATUS, OAMADDR, the PPUDATA read buffer and the
//   OAMDMA kick-off, and drives the VRAM/OAM ports and the NMI line.
// Configuration
//   PPU_OPEN_BUS_EN  when defined, an 8-bit io latch captures every write and
//                    every read result; write-only register reads and
//                    PPUSTATUS[4:0] return it. Otherwise those bits read 0.
// Ports
//   clock, reset_n            clock, asynchronous active-low reset
//   cpu_clock_en              CPU-cycle strobe qualifying every access
//   reg_sel/reg_en/reg_rw     register select, access valid, 1=write 0=read
//   reg_data_wr/reg_data_rd   CPU write data / registered read data
//   vblank_set/vblank_clear   PPU timing pulses
//   sprite0_hit/sprite_ovf    status event pulses
//   ppuctrl/ppumask           control registers
//   t_addr/fine_x             scroll state for the renderer
//   vram_addr/we/wdata/re/rdata  VRAM port; vram_rdata is sampled on the
//                             edge that ends the vram_re cycle
//   pal_rdata                 palette data, combinational on vram_addr[4:0]
//   oam_addr/we/wdata/rdata   OAM port (oam_rdata combinational)
//   dma_start/dma_page        OAMDMA kick-off
//   nmi_n                     registered ~(vblank & ppuctrl[7])
module ppu_reg_responder
  import ppu_types_pkg::*;
#(
  parameter int unsigned VRAM_AW = 14
)
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpu_clock_en,
  input  reg_t               reg_sel,
  input  logic               reg_en,
  input  logic               reg_rw,
  input  logic [7:0]         reg_data_wr,
  output logic [7:0]         reg_data_rd,
  input  logic               vblank_set,
  input  logic               vblank_clear,
  input  logic               sprite0_hit,
  input  logic               sprite_ovf,
  output logic [7:0]         ppuctrl,
  output logic [7:0]         ppumask,
  output logic [14:0]        t_addr,
  output logic [2:0]         fine_x,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  output logic               vram_re,
  input  logic [7:0]         vram_rdata,
  input  logic [7:0]         pal_rdata,
  output logic [7:0]         oam_addr,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  output logic               dma_start,
  output logic [7:0]         dma_page,
  output logic               nmi_n
);

  logic        access;
  logic        wr;
  logic        rd;
  logic        status_rd;
  logic        data_rd;
  logic        pal_access;
  logic        vblank;
  logic        s0;
  logic        ovf;
  logic [7:0]  buffer;
  logic [7:0]  rd_value;
  logic [7:0]  open_bus;
  logic [14:0] v;
  logic        v_unused;

  fill_state_t state_q;
  fill_state_t state_d;

  assign access     = cpu_clock_en & reg_en;
  assign wr         = access & reg_rw;
  assign rd         = access & ~reg_rw;
  assign status_rd  = rd & (reg_sel == REG_PPUSTATUS);
  assign data_rd    = rd & (reg_sel == REG_PPUDATA);
  assign pal_access = (v[13:8] == PAL_PAGE);
  assign vram_addr  = v[VRAM_AW-1:0];
  assign v_unused   = v[14];

  // The read strobe is the FILL state itself so that vram_addr still shows
  // the pre-increment v while it is high.
  assign vram_re = (state_q == ST_FILL);

  // v advances one clock after a PPUDATA access, once the strobe cycle at
  // the old address has been presented to VRAM.
  ppu_loopy_addr u_loopy (
    .clock     (clock),
    .reset_n   (reset_n),
    .data      (reg_data_wr),
    .ctrl_we   (wr & (reg_sel == REG_PPUCTRL)),
    .scroll_we (wr & (reg_sel == REG_PPUSCROLL)),
    .addr_we   (wr & (reg_sel == REG_PPUADDR)),
    .w_reset   (status_rd),
    .v_inc     (vram_we | vram_re),
    .inc32     (ppuctrl[2]),
    .t         (t_addr),
    .v         (v),
    .fine_x    (fine_x)
  );

`ifdef PPU_OPEN_BUS_EN
  logic [7:0] io_latch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_latch <= '0;
    end else if (wr) begin
      io_latch <= reg_data_wr;
    end else if (rd) begin
      io_latch <= rd_value;
    end
  end

  assign open_bus = io_latch;
`else
  assign open_bus = '0;
`endif

  always_comb begin
    rd_value = open_bus;
    case (reg_sel)
      REG_PPUSTATUS: rd_value = {vblank, s0, ovf, open_bus[4:0]};
      REG_OAMDATA:   rd_value = oam_rdata;
      REG_PPUDATA:   rd_value = pal_access ? pal_rdata : buffer;
      default:       rd_value = open_bus;
    endcase
  end

  // Buffer refill sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (data_rd) state_d = ST_FILL;
      ST_FILL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      buffer  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FILL) begin
        buffer <= vram_rdata;
      end
    end
  end

  // Status flags react every clock; a STATUS read wins over a same-edge
  // vblank_set, and vblank_clear wins over same-edge sprite events.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vblank <= 1'b0;
      s0     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (status_rd) begin
        vblank <= 1'b0;
      end else if (vblank_set) begin
        vblank <= 1'b1;
      end else if (vblank_clear) begin
        vblank <= 1'b0;
      end

      if (vblank_clear) begin
        s0  <= 1'b0;
        ovf <= 1'b0;
      end else begin
        if (sprite0_hit) s0  <= 1'b1;
        if (sprite_ovf)  ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ppuctrl     <= '0;
      ppumask     <= '0;
      oam_addr    <= '0;
      oam_we      <= 1'b0;
      oam_wdata   <= '0;
      vram_we     <= 1'b0;
      vram_wdata  <= '0;
      dma_start   <= 1'b0;
      dma_page    <= '0;
      reg_data_rd <= '0;
      nmi_n       <= 1'b1;
    end else begin
      vram_we   <= 1'b0;
      oam_we    <= 1'b0;
      dma_start <= 1'b0;
      nmi_n     <= ~(vblank & ppuctrl[7]);

      // OAMADDR advances after the oam_we cycle so the write lands at the
      // address in place when OAMDATA was written.
      if (oam_we) begin
        oam_addr <= oam_addr + 8'd1;
      end

      if (wr) begin
        case (reg_sel)
          REG_PPUCTRL: ppuctrl  <= reg_data_wr;
          REG_PPUMASK: ppumask  <= reg_data_wr;
          REG_OAMADDR: oam_addr <= reg_data_wr;
          REG_OAMDATA: begin
            oam_we    <= 1'b1;
            oam_wdata <= reg_data_wr;
          end
          REG_PPUDATA: begin
            vram_we    <= 1'b1;
            vram_wdata <= reg_data_wr;
          end
          REG_OAMDMA: begin
            dma_page  <= reg_data_wr;
            dma_start <= 1'b1;
          end
          default: ;
        endcase
      end

      if (rd) begin
        reg_data_rd <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_ppu_reg_responder.sv
// tb_ppu_reg_responder
//   Directed bench for ppu_reg_responder (default build, open bus disabled).
module tb_ppu_reg_responder;
  import ppu_types_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_clock_en = 1'b0;
  reg_t        reg_sel = REG_PPUCTRL;
  logic        reg_en = 1'b0;
  logic        reg_rw = 1'b0;
  logic [7:0]  reg_data_wr = '0;
  logic [7:0]  reg_data_rd;
  logic        vblank_set = 1'b0;
  logic        vblank_clear = 1'b0;
  logic        sprite0_hit = 1'b0;
  logic        sprite_ovf = 1'b0;
  logic [7:0]  ppuctrl;
  logic [7:0]  ppumask;
  logic [14:0] t_addr;
  logic [2:0]  fine_x;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        vram_re;
  logic [7:0]  vram_rdata;
  logic [7:0]  pal_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic        dma_start;
  logic [7:0]  dma_page;
  logic        nmi_n;

  int tests = 0;
  int failed = 0;

  // Memory models: VRAM byte = low address + 0xAB (0x2000 holds 0xAB)
  assign vram_rdata = vram_addr[7:0] + 8'hAB;
  assign pal_rdata  = {3'b100, vram_addr[4:0]};
  assign oam_rdata  = oam_addr ^ 8'h3C;

  ppu_reg_responder #(.VRAM_AW(14)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_clock_en(cpu_clock_en),
    .reg_sel(reg_sel), .reg_en(reg_en), .reg_rw(reg_rw),
    .reg_data_wr(reg_data_wr), .reg_data_rd(reg_data_rd),
    .vblank_set(vblank_set), .vblank_clear(vblank_clear),
    .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
    .ppuctrl(ppuctrl), .ppumask(ppumask), .t_addr(t_addr), .fine_x(fine_x),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_re(vram_re), .vram_rdata(vram_rdata), .pal_rdata(pal_rdata),
    .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
    .oam_rdata(oam_rdata), .dma_start(dma_start), .dma_page(dma_page),
    .nmi_n(nmi_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitors
  int          we_cnt = 0, oam_cnt = 0, dma_cnt = 0;
  logic [13:0] we_addr = '0;
  logic [7:0]  we_data = '0, oam_waddr = '0, oam_wd = '0;

  always @(posedge clock) begin
    if (vram_we) begin we_cnt++; we_addr = vram_addr; we_data = vram_wdata; end
    if (oam_we)  begin oam_cnt++; oam_waddr = oam_addr; oam_wd = oam_wdata; end
    if (dma_start) dma_cnt++;
    // A PPUDATA access can never land while the buffer refill is in flight
    if (reset_n && cpu_clock_en && reg_en && reg_sel == REG_PPUDATA)
      chk("data_access_in_fill", 32'(vram_re), 32'd0);
  end

  task automatic cpu_access(input reg_t sel, input logic rw, input logic [7:0] d);
    @(negedge clock);
    cpu_clock_en = 1'b1; reg_en = 1'b1; reg_sel = sel; reg_rw = rw; reg_data_wr = d;
    @(negedge clock);
    cpu_clock_en = 1'b0; reg_en = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse(input logic vs, input logic vc, input logic s0h, input logic ov);
    @(negedge clock);
    vblank_set = vs; vblank_clear = vc; sprite0_hit = s0h; sprite_ovf = ov;
    @(negedge clock);
    vblank_set = 1'b0; vblank_clear = 1'b0; sprite0_hit = 1'b0; sprite_ovf = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  typedef struct {
    reg_t        sel;
    logic        rw;
    logic [7:0]  d;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic [14:0] exp_t;
    logic [2:0]  exp_fx;
    logic [13:0] exp_v;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{REG_PPUCTRL,   1'b1, 8'h00, 1'b0, 8'h00, 15'h0000, 3'd0, 14'h0000};
    vecs[1]  = '{REG_PPUADDR,   1'b1, 8'h21, 1'b0, 8'h00, 15'h2100, 3'd0, 14'h0000};
    vecs[2]  = '{REG_PPUADDR,   1'b1, 8'h08, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2108};
    vecs[3]  = '{REG_PPUDATA,   1'b1, 8'h55, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2109};
    vecs[4]  = '{REG_PPUCTRL,   1'b1, 8'h04, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2109};
    vecs[5]  = '{REG_PPUADDR,   1'b1, 8'h21, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2109};
    vecs[6]  = '{REG_PPUADDR,   1'b1, 8'h08, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2108};
    vecs[7]  = '{REG_PPUDATA,   1'b1, 8'h66, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2128};
    vecs[8]  = '{REG_PPUCTRL,   1'b1, 8'h00, 1'b0, 8'h00, 15'h2108, 3'd0, 14'h2128};
    vecs[9]  = '{REG_PPUADDR,   1'b1, 8'h20, 1'b0, 8'h00, 15'h2008, 3'd0, 14'h2128};
    vecs[10] = '{REG_PPUADDR,   1'b1, 8'h00, 1'b0, 8'h00, 15'h2000, 3'd0, 14'h2000};
    vecs[11] = '{REG_PPUDATA,   1'b0, 8'h00, 1'b1, 8'h00, 15'h2000, 3'd0, 14'h2001};
    vecs[12] = '{REG_PPUDATA,   1'b0, 8'h00, 1'b1, 8'hAB, 15'h2000, 3'd0, 14'h2002};
    vecs[13] = '{REG_PPUSCROLL, 1'b1, 8'h7D, 1'b0, 8'h00, 15'h200F, 3'd5, 14'h2002};
    vecs[14] = '{REG_PPUSTATUS, 1'b0, 8'h00, 1'b1, 8'h00, 15'h200F, 3'd5, 14'h2002};
    vecs[15] = '{REG_PPUSCROLL, 1'b1, 8'h7D, 1'b0, 8'h00, 15'h200F, 3'd5, 14'h2002};
    vecs[16] = '{REG_PPUSCROLL, 1'b1, 8'h5E, 1'b0, 8'h00, 15'h616F, 3'd5, 14'h2002};
    vecs[17] = '{REG_PPUADDR,   1'b1, 8'h3F, 1'b0, 8'h00, 15'h3F6F, 3'd5, 14'h2002};
    vecs[18] = '{REG_PPUADDR,   1'b1, 8'h01, 1'b0, 8'h00, 15'h3F01, 3'd5, 14'h3F01};
    vecs[19] = '{REG_PPUDATA,   1'b0, 8'h00, 1'b1, 8'h81, 15'h3F01, 3'd5, 14'h3F02};
    vecs[20] = '{REG_PPUMASK,   1'b0, 8'h00, 1'b1, 8'h00, 15'h3F01, 3'd5, 14'h3F02};
    vecs[21] = '{REG_OAMDATA,   1'b0, 8'h00, 1'b1, 8'h3C, 15'h3F01, 3'd5, 14'h3F02};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_rd",     32'(reg_data_rd), 32'h00);
    chk("rst_ctrl",   32'(ppuctrl),     32'h00);
    chk("rst_t",      32'(t_addr),      32'h0000);
    chk("rst_v",      32'(vram_addr),   32'h0000);
    chk("rst_nmi_n",  32'(nmi_n),       32'd1);
    chk("rst_strobe", 32'({vram_we, vram_re, oam_we, dma_start}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      cpu_access(vecs[i].sel, vecs[i].rw, vecs[i].d);
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d_rd", i), 32'(reg_data_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_t", i),  32'(t_addr),    32'(vecs[i].exp_t));
      chk($sformatf("vec%0d_fx", i), 32'(fine_x),    32'(vecs[i].exp_fx));
      chk($sformatf("vec%0d_v", i),  32'(vram_addr), 32'(vecs[i].exp_v));
    end
    chk("vram_we_cnt",  32'(we_cnt),  32'd2);
    chk("vram_we_addr", 32'(we_addr), 32'h2108);
    chk("vram_we_data", 32'(we_data), 32'h66);

    cpu_access(REG_PPUMASK, 1'b1, 8'h1E);
    chk("mask", 32'(ppumask), 32'h1E);

    // OAM write wrap and DMA kick-off
    cpu_access(REG_OAMADDR, 1'b1, 8'hFF);
    cpu_access(REG_OAMDATA, 1'b1, 8'h12);
    chk("oam_we_cnt",  32'(oam_cnt),   32'd1);
    chk("oam_we_addr", 32'(oam_waddr), 32'hFF);
    chk("oam_we_data", 32'(oam_wd),    32'h12);
    chk("oam_wrap",    32'(oam_addr),  32'h00);
    cpu_access(REG_OAMDMA, 1'b1, 8'h02);
    chk("dma_cnt",  32'(dma_cnt),  32'd1);
    chk("dma_page", 32'(dma_page), 32'h02);

    // vblank / NMI
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nmi_ctrl_off", 32'(nmi_n), 32'd1);
    cpu_access(REG_PPUCTRL, 1'b1, 8'h80);
    chk("nmi_ctrl_on", 32'(nmi_n), 32'd0);
    cpu_access(REG_PPUSTATUS, 1'b0, 8'h00);
    chk("status_vbl", 32'(reg_data_rd), 32'h80);
    chk("nmi_release", 32'(nmi_n), 32'd1);
    cpu_access(REG_PPUSTATUS, 1'b0, 8'h00);
    chk("status_clr", 32'(reg_data_rd), 32'h00);

    @(negedge clock);
    cpu_clock_en = 1'b1; reg_en = 1'b1; reg_sel = REG_PPUSTATUS; reg_rw = 1'b0;
    vblank_set = 1'b1;
    @(negedge clock);
    cpu_clock_en = 1'b0; reg_en = 1'b0; vblank_set = 1'b0;
    repeat (2) @(negedge clock);
    chk("race_rd",  32'(reg_data_rd), 32'h00);
    chk("race_nmi", 32'(nmi_n),       32'd1);
    cpu_access(REG_PPUSTATUS, 1'b0, 8'h00);
    chk("race_flag", 32'(reg_data_rd), 32'h00);

    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    cpu_access(REG_PPUSTATUS, 1'b0, 8'h00);
    chk("status_s0_ovf", 32'(reg_data_rd), 32'h60);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    cpu_access(REG_PPUSTATUS, 1'b0, 8'h00);
    chk("status_vclr", 32'(reg_data_rd), 32'h00);

    // Reset while the buffer refill is pending
    cpu_access(REG_PPUADDR, 1'b1, 8'h20);
    cpu_access(REG_PPUADDR, 1'b1, 8'h05);
    @(negedge clock);
    cpu_clock_en = 1'b1; reg_en = 1'b1; reg_sel = REG_PPUDATA; reg_rw = 1'b0;
    @(posedge clock);
    #1;
    chk("fill_re", 32'(vram_re), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("fillrst_re",   32'(vram_re),     32'd0);
    chk("fillrst_v",    32'(vram_addr),   32'h0000);
    chk("fillrst_t",    32'(t_addr),      32'h0000);
    chk("fillrst_ctrl", 32'(ppuctrl),     32'h00);
    chk("fillrst_mask", 32'(ppumask),     32'h00);
    chk("fillrst_rd",   32'(reg_data_rd), 32'h00);
    @(negedge clock);
    cpu_clock_en = 1'b0; reg_en = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    cpu_access(REG_PPUADDR, 1'b1, 8'h20);
    cpu_access(REG_PPUADDR, 1'b1, 8'h05);
    cpu_access(REG_PPUDATA, 1'b0, 8'h00);
    chk("fillrst_buf", 32'(reg_data_rd), 32'h00);
    chk("fillrst_vinc", 32'(vram_addr), 32'h2006);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
